// File: rtl/mspu_dump_pkg.sv
// Shared types and constants for the memory-dump-to-UART path.
package mspu_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        GAP,
        FIN
    } dump_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/mem_dump_tx.sv
// Streams a block of 32-bit memory words out to a UART byte transmitter, MSB first.
// Every output is a register loaded from the next-state decode, so the strobes line up with the state.
module mem_dump_tx
    import mspu_dump_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              tx_wr,
    output logic [7:0]        tx_din,
    input  logic              tx_ready
);

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    dump_state_t             state, state_nxt;
    logic [31:0]             shift, shift_nxt;
    logic [BYTE_IDX_W-1:0]   byte_idx, byte_idx_nxt;
    logic [CNT_W-1:0]        remaining, remaining_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [7:0]              din_nxt;
    logic                    wr_nxt;

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        byte_idx_nxt  = byte_idx;
        remaining_nxt = remaining;
        addr_nxt      = mem_addr;
        din_nxt       = tx_din;
        wr_nxt        = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr_nxt      = base_addr;
                            remaining_nxt = word_count;
                            state_nxt     = READ;
                        end else begin
                            state_nxt = FIN;
                        end
                    end
                end
                READ: state_nxt = LATCH;
                LATCH: begin
                    // Read data lands this cycle; the first byte is staged so it can go out next cycle.
                    shift_nxt    = mem_rdata;
                    byte_idx_nxt = '0;
                    din_nxt      = mem_rdata[31:24];
                    wr_nxt       = tx_ready;
                    state_nxt    = SEND;
                end
                SEND: begin
                    // tx_wr high means the byte is being strobed right now.
                    if (tx_wr) begin
                        state_nxt = GAP;
                    end else if (tx_ready) begin
                        wr_nxt = 1'b1;
                    end
                end
                GAP: begin
                    if (byte_idx != LAST_BYTE) begin
                        shift_nxt    = shift << 8;
                        byte_idx_nxt = byte_idx + BYTE_IDX_W'(1);
                        din_nxt      = shift[23:16];
                        wr_nxt       = tx_ready;
                        state_nxt    = SEND;
                    end else if (remaining > CNT_W'(1)) begin
                        remaining_nxt = remaining - CNT_W'(1);
                        addr_nxt      = mem_addr + ADDR_W'(1);
                        state_nxt     = READ;
                    end else begin
                        state_nxt = FIN;
                    end
                end
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_re    <= 1'b0;
            tx_wr     <= 1'b0;
            mem_addr  <= '0;
            tx_din    <= '0;
            shift     <= '0;
            byte_idx  <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == FIN);
            mem_re    <= (state_nxt == READ);
            tx_wr     <= wr_nxt;
            mem_addr  <= addr_nxt;
            tx_din    <= din_nxt;
            shift     <= shift_nxt;
            byte_idx  <= byte_idx_nxt;
            remaining <= remaining_nxt;
        end
    end

endmodule
